dsp_mac_pipe: RTL and testbench
===============================

Name: dsp_mac_pipe

Overview:
- Parametrised multiply-accumulate datapath for the DSP core, replacing the fixed 16/32-bit T/P/accumulator path.
- Holds the T (multiplicand), P (product) and accumulator registers behind a two-stage pipeline.
- Adds saturation mode, a sticky overflow flag, a stall input and a result-valid strobe; the control unit issues one op per cycle.

Parameters:
- DATA_W, 16, operand width of din and T; signed two's complement.
- ACC_W, 32, width of P and accumulator; must be >= 2*DATA_W (elaboration error otherwise).
- SAT_EN, 1, 1 = saturation logic built and sat_mode honoured; 0 = sat_mode ignored, always wrap.

Ports:
- clk, input, 1, rising-edge clock.
- reset, input, 1, synchronous, active-low reset (0 = reset).
- in_valid, input, 1, op/din valid this cycle.
- op, input, 3, operation code.
- din, input, DATA_W, signed operand.
- stall, input, 1, freeze both stages; in_valid ignored while high.
- sat_mode, input, 1, 1 = saturate accumulator results, 0 = wrap.
- t_out, output, DATA_W, T register.
- p_out, output, ACC_W, P register.
- acc_out, output, ACC_W, accumulator.
- acc_valid, output, 1, one-cycle pulse after each accumulator write.
- ovf, output, 1, sticky overflow flag.
- acc_zero, output, 1, combinational: acc_out == 0.

Behaviour:
- Reset: on a clock edge with reset low, T, P, ACC, ovf, acc_valid and the stage-2 valid bit all go to 0. Reset takes priority over stall and in_valid. An op in flight in stage 2 is discarded and produces no acc_valid.
- Op codes:
  - 0 NOP.
  - 1 LT: T <= din.
  - 2 MPY: P <= sign-extended (T * din).
  - 3 LTA: ACC <= ACC + P; T <= din.
  - 4 APAC: ACC <= ACC + P.
  - 5 SPAC: ACC <= ACC - P.
  - 6 ZAC: ACC <= 0; clears ovf.
  - 7 LACC: ACC <= sign-extended din.
- Stage 1 (edge E at which in_valid=1 and stall=0):
  - T and P are written at E.
  - MPY uses the T value before E, i.e. it sees a T loaded by any op accepted at an earlier edge.
  - The op code is latched into stage 2.
- Stage 2 (edge E+1, if stall=0):
  - ACC ops (3-7) write ACC using the P value held between E and E+1.
  - Result: strict program order with no hazards, no stalls and no forwarding required.
  - acc_valid is high during the cycle after the ACC write; it is 0 for NOP, LT and MPY.
- Latency:
  - T/P: 1 edge.
  - ACC: 2 edges.
  - Throughput: one op per cycle.
- Stall:
  - While stall=1, all registers hold, stage 2 does not advance and acc_valid is 0.
  - A pending stage-2 op completes at the first unstalled edge.
- Arithmetic:
  - Add/sub is computed in ACC_W+1 bits.
  - Overflow = the two top bits of the result differ.
  - On overflow, ovf <= 1 (sticky until ZAC or reset).
  - With sat_mode=1 and SAT_EN=1, ACC takes the signed max 0x7FF..F or min 0x800..0; otherwise ACC takes the low ACC_W bits (wrap).
  - The product is always exact, since ACC_W >= 2*DATA_W; the single corner case -2^(DATA_W-1) squared is still representable in 2*DATA_W bits.
- Simultaneous events:
  - LTA writes T at stage 1 and ACC at stage 2, independently.
  - ZAC completing on the same edge as an overflow-free op leaves ovf cleared.
- in_valid=0 (or NOP) inserts a bubble. T and P hold.

Test Plan:
- Reset: hold reset=0 for 2 cycles with in_valid=1, op=7, din=5 → t_out=0, p_out=0, acc_out=0, ovf=0, acc_valid=0, acc_zero=1.
- Basic path: LT 1, MPY 1, APAC back-to-back → after 4 edges t_out=0x0001, p_out=0x00000001, acc_out=0x00000001, single acc_valid pulse.
- Program order: LT 3, MPY 4, LTA 5, MPY -2, APAC consecutive →
  - P=12, then ACC=12 with T=5;
  - P=-10 (0xFFFFFFF6);
  - final ACC=2.
- Overflow/saturation: LT 0x8000, MPY 0x8000 (P=0x40000000), APAC, APAC →
  - sat_mode=1: ACC=0x7FFFFFFF, ovf=1.
  - sat_mode=0: ACC=0x80000000, ovf=1.
  - Then ZAC: ACC=0, ovf=0.
- Stall: MPY 7 with T=2, then APAC, with stall=1 for 3 cycles immediately after APAC is accepted → ACC stays 0 and acc_valid stays 0 during the stall; ACC=14 at the first unstalled edge, followed by a one-cycle acc_valid.
- Reset mid-op: accept LACC 0x1234, drive reset=0 on the next edge → acc_out=0, no acc_valid. After release, LACC 0x8000 → ACC=0xFFFF8000.

Source files
------------

// File: rtl/dsp_mac_pipe.sv
// Two-stage T/P/accumulator MAC: T and P update 1 edge after accept, ACC 2 edges after.
// stall freezes both stages and blocks new ops; one op per cycle otherwise.
module dsp_mac_pipe #(
  parameter int DATA_W = 16,
  parameter int ACC_W  = 32,
  parameter int SAT_EN = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [2:0]        op,
  input  logic [DATA_W-1:0] din,
  input  logic              stall,
  input  logic              sat_mode,
  output logic [DATA_W-1:0] t_out,
  output logic [ACC_W-1:0]  p_out,
  output logic [ACC_W-1:0]  acc_out,
  output logic              acc_valid,
  output logic              ovf,
  output logic              acc_zero
);

  localparam logic [2:0] OP_NOP  = 3'd0;
  localparam logic [2:0] OP_LT   = 3'd1;
  localparam logic [2:0] OP_MPY  = 3'd2;
  localparam logic [2:0] OP_LTA  = 3'd3;
  localparam logic [2:0] OP_APAC = 3'd4;
  localparam logic [2:0] OP_SPAC = 3'd5;
  localparam logic [2:0] OP_ZAC  = 3'd6;
  localparam logic [2:0] OP_LACC = 3'd7;

  if (ACC_W < 2*DATA_W) begin : g_width_check
    $error("dsp_mac_pipe: ACC_W must be at least 2*DATA_W");
  end

  logic [DATA_W-1:0] t_q;
  logic [ACC_W-1:0]  p_q;
  logic [ACC_W-1:0]  acc_q;
  logic              acc_vld_q;
  logic              ovf_q;
  logic              s2_vld;
  logic [2:0]        s2_op;
  logic [DATA_W-1:0] s2_din;

  logic signed [2*DATA_W-1:0] prod;
  logic [ACC_W-1:0]           p_next;
  logic signed [ACC_W:0]      acc_x;
  logic signed [ACC_W:0]      p_x;
  logic signed [ACC_W:0]      sum;
  logic                       ovf_now;
  logic                       sat_on;
  logic [ACC_W-1:0]           acc_arith;
  logic [ACC_W-1:0]           lacc_val;

  // Full-width signed product is exact, even for the most-negative operand squared.
  assign prod     = (2*DATA_W)'($signed(t_q)) * (2*DATA_W)'($signed(din));
  assign p_next   = ACC_W'(prod);
  assign acc_x    = (ACC_W+1)'($signed(acc_q));
  assign p_x      = (ACC_W+1)'($signed(p_q));
  assign lacc_val = ACC_W'($signed(s2_din));
  assign sat_on   = (SAT_EN != 0) && sat_mode;

  always_comb begin
    sum       = (s2_op == OP_SPAC) ? (acc_x - p_x) : (acc_x + p_x);
    ovf_now   = sum[ACC_W] ^ sum[ACC_W-1];
    acc_arith = sum[ACC_W-1:0];
    if (ovf_now && sat_on) begin
      acc_arith = sum[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      t_q       <= '0;
      p_q       <= '0;
      acc_q     <= '0;
      acc_vld_q <= 1'b0;
      ovf_q     <= 1'b0;
      s2_vld    <= 1'b0;
      s2_op     <= OP_NOP;
      s2_din    <= '0;
    end else if (stall) begin
      acc_vld_q <= 1'b0;
    end else begin
      acc_vld_q <= 1'b0;
      s2_vld    <= in_valid;
      s2_op     <= op;
      s2_din    <= din;
      if (in_valid) begin
        case (op)
          OP_LT, OP_LTA: t_q <= din;
          OP_MPY:        p_q <= p_next;
          default:       ;
        endcase
      end
      // Stage 2 reads the P that was current before this edge, so MPY->APAC needs no bypass.
      if (s2_vld) begin
        case (s2_op)
          OP_LTA, OP_APAC, OP_SPAC: begin
            acc_q     <= acc_arith;
            acc_vld_q <= 1'b1;
            if (ovf_now) ovf_q <= 1'b1;
          end
          OP_ZAC: begin
            acc_q     <= '0;
            ovf_q     <= 1'b0;
            acc_vld_q <= 1'b1;
          end
          OP_LACC: begin
            acc_q     <= lacc_val;
            acc_vld_q <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  assign t_out     = t_q;
  assign p_out     = p_q;
  assign acc_out   = acc_q;
  assign acc_valid = acc_vld_q;
  assign ovf       = ovf_q;
  assign acc_zero  = (acc_q == '0);

endmodule

// File: tb/tb_dsp_mac_pipe.sv
// Directed bench for dsp_mac_pipe with hand-computed expectations, one task per scenario.
module tb_dsp_mac_pipe;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic [2:0]  op;
  logic [15:0] din;
  logic        stall;
  logic        sat_mode;
  logic [15:0] t_out;
  logic [31:0] p_out;
  logic [31:0] acc_out;
  logic        acc_valid;
  logic        ovf;
  logic        acc_zero;

  int checks = 0;
  int errors = 0;

  localparam logic [2:0] NOP = 3'd0, LT = 3'd1, MPY = 3'd2, LTA = 3'd3,
                         APAC = 3'd4, SPAC = 3'd5, ZAC = 3'd6, LACC = 3'd7;

  dsp_mac_pipe #(.DATA_W(16), .ACC_W(32), .SAT_EN(1)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .op(op), .din(din),
    .stall(stall), .sat_mode(sat_mode), .t_out(t_out), .p_out(p_out),
    .acc_out(acc_out), .acc_valid(acc_valid), .ovf(ovf), .acc_zero(acc_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic drive(input logic v, input logic [2:0] o, input logic [15:0] d);
    in_valid = v;
    op       = o;
    din      = d;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    drive(1'b1, LACC, 16'd5);
    tick();
    tick();
    checks++; if (t_out !== 16'h0) begin errors++; $display("FAIL reset_t: got %h want 0000", t_out); end
    checks++; if (p_out !== 32'h0) begin errors++; $display("FAIL reset_p: got %h want 00000000", p_out); end
    checks++; if (acc_out !== 32'h0) begin errors++; $display("FAIL reset_acc: got %h want 00000000", acc_out); end
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b want 0", ovf); end
    checks++; if (acc_valid !== 1'b0) begin errors++; $display("FAIL reset_accvalid: got %b want 0", acc_valid); end
    checks++; if (acc_zero !== 1'b1) begin errors++; $display("FAIL reset_acczero: got %b want 1", acc_zero); end
    drive(1'b0, NOP, 16'd0);
    reset = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    int pulses = 0;
    drive(1'b1, LT, 16'd1);   tick(); pulses += int'(acc_valid);
    drive(1'b1, MPY, 16'd1);  tick(); pulses += int'(acc_valid);
    drive(1'b1, APAC, 16'd0); tick(); pulses += int'(acc_valid);
    drive(1'b0, NOP, 16'd0);  tick(); pulses += int'(acc_valid);
    checks++; if (t_out !== 16'h0001) begin errors++; $display("FAIL basic_t: got %h want 0001", t_out); end
    checks++; if (p_out !== 32'h1) begin errors++; $display("FAIL basic_p: got %h want 00000001", p_out); end
    checks++; if (acc_out !== 32'h1) begin errors++; $display("FAIL basic_acc: got %h want 00000001", acc_out); end
    checks++; if (acc_valid !== 1'b1) begin errors++; $display("FAIL basic_accvalid: got %b want 1", acc_valid); end
    tick(); pulses += int'(acc_valid);
    checks++; if (pulses != 1) begin errors++; $display("FAIL basic_pulses: got %0d want 1", pulses); end
    checks++; if (acc_zero !== 1'b0) begin errors++; $display("FAIL basic_acczero: got %b want 0", acc_zero); end
  endtask

  task automatic test_program_order();
    drive(1'b1, ZAC, 16'd0);  tick();
    drive(1'b1, LT, 16'd3);   tick();
    drive(1'b1, MPY, 16'd4);  tick();
    checks++; if (p_out !== 32'd12) begin errors++; $display("FAIL order_p12: got %h want 0000000c", p_out); end
    drive(1'b1, LTA, 16'd5);  tick();
    checks++; if (t_out !== 16'd5) begin errors++; $display("FAIL order_t5: got %h want 0005", t_out); end
    checks++; if (acc_out !== 32'd0) begin errors++; $display("FAIL order_acc0: got %h want 00000000", acc_out); end
    drive(1'b1, MPY, 16'hFFFE); tick();
    checks++; if (acc_out !== 32'd12) begin errors++; $display("FAIL order_acc12: got %h want 0000000c", acc_out); end
    checks++; if (p_out !== 32'hFFFFFFF6) begin errors++; $display("FAIL order_pneg: got %h want fffffff6", p_out); end
    checks++; if (acc_valid !== 1'b1) begin errors++; $display("FAIL order_lta_valid: got %b want 1", acc_valid); end
    drive(1'b1, APAC, 16'd0); tick();
    drive(1'b0, NOP, 16'd0);  tick();
    checks++; if (acc_out !== 32'd2) begin errors++; $display("FAIL order_acc2: got %h want 00000002", acc_out); end
  endtask

  task automatic test_overflow(input logic sm, input logic [31:0] exp_acc);
    sat_mode = sm;
    drive(1'b1, ZAC, 16'd0);     tick();
    drive(1'b1, LT, 16'h8000);   tick();
    drive(1'b1, MPY, 16'h8000);  tick();
    checks++; if (p_out !== 32'h40000000) begin errors++; $display("FAIL ovf_p sat=%b: got %h want 40000000", sm, p_out); end
    drive(1'b1, APAC, 16'd0);    tick();
    drive(1'b1, APAC, 16'd0);    tick();
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL ovf_early sat=%b: got %b want 0", sm, ovf); end
    drive(1'b0, NOP, 16'd0);     tick();
    checks++; if (acc_out !== exp_acc) begin errors++; $display("FAIL ovf_acc sat=%b: got %h want %h", sm, acc_out, exp_acc); end
    checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL ovf_flag sat=%b: got %b want 1", sm, ovf); end
    drive(1'b1, ZAC, 16'd0);     tick();
    drive(1'b0, NOP, 16'd0);     tick();
    checks++; if (acc_out !== 32'h0) begin errors++; $display("FAIL ovf_zac_acc sat=%b: got %h want 00000000", sm, acc_out); end
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL ovf_zac_flag sat=%b: got %b want 0", sm, ovf); end
    sat_mode = 1'b1;
  endtask

  task automatic test_spac_min();
    drive(1'b1, ZAC, 16'd0);     tick();
    drive(1'b1, LACC, 16'h8000); tick();
    drive(1'b1, SPAC, 16'd0);    tick();
    drive(1'b1, SPAC, 16'd0);    tick();
    checks++; if (acc_out !== 32'hBFFF8000) begin errors++; $display("FAIL spac_first: got %h want bfff8000", acc_out); end
    drive(1'b0, NOP, 16'd0);     tick();
    checks++; if (acc_out !== 32'h80000000) begin errors++; $display("FAIL spac_satmin: got %h want 80000000", acc_out); end
    checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL spac_ovf: got %b want 1", ovf); end
    drive(1'b1, ZAC, 16'd0);     tick();
    drive(1'b0, NOP, 16'd0);     tick();
  endtask

  task automatic test_stall();
    drive(1'b1, LT, 16'd2);   tick();
    drive(1'b1, MPY, 16'd7);  tick();
    drive(1'b1, APAC, 16'd0); tick();
    stall = 1'b1;
    drive(1'b1, LT, 16'd99);
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (acc_out !== 32'h0) begin errors++; $display("FAIL stall_acc%0d: got %h want 00000000", i, acc_out); end
      checks++; if (acc_valid !== 1'b0) begin errors++; $display("FAIL stall_valid%0d: got %b want 0", i, acc_valid); end
    end
    checks++; if (t_out !== 16'd2) begin errors++; $display("FAIL stall_t_hold: got %h want 0002", t_out); end
    stall = 1'b0;
    drive(1'b0, NOP, 16'd0);  tick();
    checks++; if (acc_out !== 32'd14) begin errors++; $display("FAIL stall_acc14: got %h want 0000000e", acc_out); end
    checks++; if (acc_valid !== 1'b1) begin errors++; $display("FAIL stall_release_valid: got %b want 1", acc_valid); end
    tick();
    checks++; if (acc_valid !== 1'b0) begin errors++; $display("FAIL stall_pulse_end: got %b want 0", acc_valid); end
  endtask

  task automatic test_reset_mid_op();
    drive(1'b1, LACC, 16'h1234); tick();
    reset = 1'b0;
    drive(1'b0, NOP, 16'd0);     tick();
    checks++; if (acc_out !== 32'h0) begin errors++; $display("FAIL midrst_acc: got %h want 00000000", acc_out); end
    checks++; if (acc_valid !== 1'b0) begin errors++; $display("FAIL midrst_valid: got %b want 0", acc_valid); end
    reset = 1'b1;                tick();
    checks++; if (acc_valid !== 1'b0) begin errors++; $display("FAIL midrst_after_valid: got %b want 0", acc_valid); end
    checks++; if (acc_out !== 32'h0) begin errors++; $display("FAIL midrst_after_acc: got %h want 00000000", acc_out); end
    drive(1'b1, LACC, 16'h8000); tick();
    drive(1'b0, NOP, 16'd0);     tick();
    checks++; if (acc_out !== 32'hFFFF8000) begin errors++; $display("FAIL midrst_lacc: got %h want ffff8000", acc_out); end
    checks++; if (acc_valid !== 1'b1) begin errors++; $display("FAIL midrst_lacc_valid: got %b want 1", acc_valid); end
  endtask

  initial begin
    reset    = 1'b0;
    stall    = 1'b0;
    sat_mode = 1'b1;
    drive(1'b0, NOP, 16'd0);
    test_reset();
    test_basic();
    test_program_order();
    test_overflow(1'b1, 32'h7FFFFFFF);
    test_overflow(1'b0, 32'h80000000);
    test_spac_min();
    test_stall();
    test_reset_mid_op();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
